prio_encoder: RTL and testbench
===============================

Name: prio_encoder

Overview:
Registered priority encoder that converts a WIDTH-bit request vector into the binary index of its highest set bit. Also produces a valid flag when any bit is set. Intended as a general arbitration and index helper in the iCE40 fabric, for example button, IRQ or channel selection. Default configuration is 4-to-2.

Parameters:
WIDTH, 4, number of request inputs; legal range 2..32.
OUT_W, $clog2(WIDTH), width of the encoded index; derived, not to be overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
en  input  1  capture enable; when 0, all outputs hold their current value.
in  input  WIDTH  request vector; bit i set means request i is active.
out  output  OUT_W  index of the highest set bit in the last captured vector.
valid  output  1  1 when the last captured vector had at least one bit set.
multi  output  1  present only with MULTI_DET_EN; 1 when the last captured vector had two or more bits set.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out=0, valid=0 and multi=0. Reset has priority over en.
- Capture: on a rising edge with rst_n=1 and en=1, register the following:
  - out = index of the most significant 1 in in.
  - valid = OR-reduction of in.
  - multi = 1 when popcount(in) >= 2.
- Latency: exactly 1 clk from in to outputs. Outputs are driven purely from registers, with no combinational path from in.
- Hold: with en=0, all outputs keep their previous values indefinitely.
- Zero input: in=0 gives out=0 and valid=0. Consumers must qualify out with valid.
- Priority rule: the MSB wins. Example: 1010 encodes to 3 and 0111 encodes to 2.
- Single-hot input: out equals the exact bit position.
- Non-power-of-two WIDTH: indices 0..WIDTH-1 only; values of out at or above WIDTH are never produced.
- Inputs are treated as 2-state. X or Z on in gives undefined out, valid and multi for that capture only. The next capture of a clean vector fully recovers.
- Reset asserted mid-stream clears outputs on that same edge. The first capture after reset release happens on the first edge with rst_n=1 and en=1.

Optional Feature:
MULTI_DET_EN
- Defined: the multi output port exists and the popcount≥2 detect logic is built. This is a registered flag with the same latency, reset and hold rules as valid.
- Undefined: the multi port and its logic are absent. out and valid behave identically either way.

Decomposition:
- Shared package prio_encoder_pkg holds:
  - DEFAULT_WIDTH = 4.
  - A helper function computing the index width (clog2 with a minimum of 1).
- One natural sub-module, prio_encoder_core. It is purely combinational: in[WIDTH-1:0] feeds idx[OUT_W-1:0], any and many. It is implemented as an MSB-first scan loop.
- The top level prio_encoder instantiates the core and adds the reset and enable registers. The many output and its register sit under MULTI_DET_EN.

Test Plan:
- Reset with rst_n=0 and in=1111 for 2 clocks -> out=0, valid=0, multi=0. On release with in=0100 and en=1 -> next edge gives out=2, valid=1.
- Single-hot sweep with en=1, applying 0001, 0010, 0100, 1000 on consecutive clocks -> one clock later out=0,1,2,3 respectively, valid=1, multi=0.
- Multi-hot inputs 1010, 0111, 0011 -> out=3, 2, 1 respectively, valid=1, multi=1 (with MULTI_DET_EN defined).
- Zero input: in=0000 after in=1000 -> out=0, valid=0, multi=0 on the next edge.
- Enable hold: capture 0010 (out=1), then set en=0 and apply 1000 for 3 clocks -> out stays 1 and valid stays 1. Set en=1 -> next edge gives out=3.
- Reset mid-stream: during an out=3 stream, assert rst_n=0 for one edge with en=1 -> outputs clear on that edge. Deassert with in=0001 -> out=0, valid=1 one clock later.

Source files
------------

// File: rtl/prio_encoder_pkg.sv
// prio_encoder_pkg: shared width defaults and index-width helper for prio_encoder.
package prio_encoder_pkg;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int idx_w(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/prio_encoder_core.sv
// prio_encoder_core: combinational MSB-first scan giving highest-set index, any-set and (MULTI_DET_EN) two-or-more-set.
module prio_encoder_core #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 2
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] idx,
  output logic             any
`ifdef MULTI_DET_EN
  ,
  output logic             many
`endif
);
  always_comb begin
    idx = '0;
    any = 1'b0;
`ifdef MULTI_DET_EN
    many = 1'b0;
`endif
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) begin
`ifdef MULTI_DET_EN
        many = many | any;
`endif
        idx = any ? idx : OUT_W'(i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prio_encoder.sv
// prio_encoder: registered priority encoder (highest set bit wins) with capture enable.
// Optional multi (two-or-more bits set) flag built when MULTI_DET_EN is defined.
module prio_encoder
  import prio_encoder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int OUT_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef MULTI_DET_EN
  ,
  output logic             multi
`endif
);
  logic [OUT_W-1:0] idx;
  logic             any;
`ifdef MULTI_DET_EN
  logic             many;
`endif
  prio_encoder_core #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_core (
    .in  (in),
    .idx (idx),
    .any (any)
`ifdef MULTI_DET_EN
    ,
    .many(many)
`endif
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      out   <= idx;
      valid <= any;
    end
  end
`ifdef MULTI_DET_EN
  always_ff @(posedge clk) begin
    if (!rst_n) multi <= 1'b0;
    else if (en) multi <= many;
  end
`endif
endmodule

// File: tb/tb_prio_encoder.sv
// tb_prio_encoder: table-driven directed vectors plus randomized checks against a behavioural model.
module tb_prio_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] in4 = '0;
  logic [4:0] in5 = '0;
  logic [1:0] out4;
  logic [2:0] out5;
  logic       valid4, valid5;
`ifdef MULTI_DET_EN
  logic       multi4, multi5;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prio_encoder #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (in4),
    .out  (out4),
    .valid(valid4)
`ifdef MULTI_DET_EN
    ,
    .multi(multi4)
`endif
  );

  prio_encoder #(.WIDTH(5)) dut5 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (in5),
    .out  (out5),
    .valid(valid5)
`ifdef MULTI_DET_EN
    ,
    .multi(multi5)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] in;
    logic [1:0] out;
    logic       valid;
    logic       multi;
  } vec_t;

  vec_t tbl [0:22];

  function automatic int msb(input int unsigned v);
    int unsigned x = v;
    int n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input int idx, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int e4_out, e4_valid, e4_multi, e5_out, e5_valid, e5_multi;

  initial begin
    tbl = '{
      '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1},
      '{1'b1, 1'b1, 4'b0111, 2'd2, 1'b1, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 2'd1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 4'b1000, 2'd1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 4'b1000, 2'd1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 4'b1000, 2'd1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'b1000, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 4'b0111, 2'd2, 1'b1, 1'b1},
      '{1'b1, 1'b0, 4'b0001, 2'd2, 1'b1, 1'b1},
      '{1'b1, 1'b0, 4'b1000, 2'd2, 1'b1, 1'b1}
    };
    #1;
    for (int i = 0; i < 23; i++) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      in4   = tbl[i].in;
      tick();
      check("tbl_out", i, int'(out4), int'(tbl[i].out));
      check("tbl_valid", i, int'(valid4), int'(tbl[i].valid));
`ifdef MULTI_DET_EN
      check("tbl_multi", i, int'(multi4), int'(tbl[i].multi));
`endif
    end

    rst_n = 1'b0;
    en = 1'b0;
    tick();
    {e4_out, e4_valid, e4_multi, e5_out, e5_valid, e5_multi} = '0;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      en    = ($urandom_range(0, 3) != 0);
      in4   = 4'($urandom);
      in5   = 5'($urandom);
      if (!rst_n) begin
        {e4_out, e4_valid, e4_multi, e5_out, e5_valid, e5_multi} = '0;
      end else if (en) begin
        e4_valid = (in4 != 0);
        e4_out   = e4_valid ? msb(int'(in4)) : 0;
        e4_multi = ($countones(in4) >= 2);
        e5_valid = (in5 != 0);
        e5_out   = e5_valid ? msb(int'(in5)) : 0;
        e5_multi = ($countones(in5) >= 2);
      end
      tick();
      check("rnd4_out", i, int'(out4), e4_out);
      check("rnd4_valid", i, int'(valid4), e4_valid);
      check("rnd5_out", i, int'(out5), e5_out);
      check("rnd5_valid", i, int'(valid5), e5_valid);
`ifdef MULTI_DET_EN
      check("rnd4_multi", i, int'(multi4), e4_multi);
      check("rnd5_multi", i, int'(multi5), e5_multi);
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
